// File: rtl/rot_ctrl_pkg.sv
// Shared types and constants for the rotary-encoder mode controller.
package rot_ctrl_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    FREEZE = 2'd2
  } mode_e;

  localparam logic [2:0] SPEED_MAX = 3'd7;
  localparam logic [7:0] LED_RESET = 8'h01;

  function automatic logic [7:0] rot_left(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] rot_right(input logic [7:0] v);
    return {v[0], v[7:1]};
  endfunction

endpackage

// File: rtl/rotary_mode_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, one-cycle press pulse.
// A level change is accepted after DEB_CYCLES consecutive differing samples; press follows one cycle later.
import rot_ctrl_pkg::*;

module btn_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    // Any sample agreeing with the accepted level restarts the stability run.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/rotary_mode_ctrl.sv
// Rotary mode controller: MANUAL / AUTO / FREEZE LED sequencing; all outputs registered, 1-cycle response.
// Optional ROT_CTRL_PINGPONG_EN: AUTO bounces at the LED ends instead of wrapping.
import rot_ctrl_pkg::*;

module rotary_mode_ctrl #(
  parameter int TICK_BASE  = 1_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rot_event,
  input  logic       rot_dir,
  input  logic       btn,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic [2:0] speed
);

  localparam int PW = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_BASE - 1);

  mode_e         mode_q, mode_d;
  logic [7:0]    led_q, led_d;
  logic [2:0]    speed_q, speed_d;
  logic          dir_q, dir_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    step_q, step_d;
  logic          press;
  logic          tick;
  logic          step;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (press)
  );

  always_comb begin
    mode_d  = mode_q;
    led_d   = led_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    presc_d = presc_q;
    step_d  = step_q;
    tick    = 1'b0;
    step    = 1'b0;
    // A press owns the cycle: any coincident rotary event or auto step is dropped.
    if (press) begin
      case (mode_q)
        MANUAL: begin
          mode_d  = AUTO;
          presc_d = '0;
          step_d  = '0;
        end
        AUTO:    mode_d = FREEZE;
        FREEZE:  mode_d = MANUAL;
        default: mode_d = MANUAL;
      endcase
    end else begin
      case (mode_q)
        MANUAL: begin
          if (rot_event) begin
            led_d = rot_dir ? rot_left(led_q) : rot_right(led_q);
            dir_d = rot_dir;
          end
        end
        AUTO: begin
          if (rot_event) begin
            if (rot_dir && speed_q != SPEED_MAX) speed_d = speed_q + 3'd1;
            else if (!rot_dir && speed_q != 3'd0) speed_d = speed_q - 3'd1;
          end
          tick    = (presc_q == PRESC_LAST);
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            // >= rather than == so a period lowered below the count fires at once.
            if (({1'b0, step_q} + 4'd1) >= (4'd8 - {1'b0, speed_q})) begin
              step   = 1'b1;
              step_d = '0;
            end else begin
              step_d = step_q + 3'd1;
            end
          end
          if (step) begin
`ifdef ROT_CTRL_PINGPONG_EN
            if (dir_q && led_q == 8'h80) begin
              dir_d = 1'b0;
              led_d = 8'h40;
            end else if (!dir_q && led_q == 8'h01) begin
              dir_d = 1'b1;
              led_d = 8'h02;
            end else begin
              led_d = dir_q ? rot_left(led_q) : rot_right(led_q);
            end
`else
            led_d = dir_q ? rot_left(led_q) : rot_right(led_q);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MANUAL;
      led_q   <= LED_RESET;
      speed_q <= 3'd0;
      dir_q   <= 1'b1;
      presc_q <= '0;
      step_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      led_q   <= led_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
      presc_q <= presc_d;
      step_q  <= step_d;
    end
  end

  assign led   = led_q;
  assign mode  = mode_q;
  assign speed = speed_q;

endmodule

// File: tb/tb_rotary_mode_ctrl.sv
// Directed bench for rotary_mode_ctrl with TICK_BASE=4, DEB_CYCLES=3.
module tb_rotary_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rot_event;
  logic       rot_dir;
  logic       btn;
  logic [7:0] led;
  logic [1:0] mode;
  logic [2:0] speed;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       dir;
    logic       chk_led;
    logic [7:0] led;
    logic [2:0] speed;
    logic [1:0] mode;
  } vec_t;

  vec_t vt[25];

  rotary_mode_ctrl #(.TICK_BASE(4), .DEB_CYCLES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .rot_event (rot_event),
    .rot_dir   (rot_dir),
    .btn       (btn),
    .led       (led),
    .mode      (mode),
    .speed     (speed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rot_event = 1'b1;
      rot_dir   = vt[i].dir;
      tick();
      rot_event = 1'b0;
      if (vt[i].chk_led) chk($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, vt[i].led});
      chk($sformatf("vec%0d_speed", i), {29'd0, speed}, {29'd0, vt[i].speed});
      chk($sformatf("vec%0d_mode", i), {30'd0, mode}, {30'd0, vt[i].mode});
    end
  endtask

  // Button held until the mode flips exactly 2+3+1 edges later, then released and settled.
  task automatic press_btn(input logic [1:0] old_mode, input logic [1:0] new_mode, input string name);
    btn = 1'b1;
    repeat (5) tick();
    chk({name, "_early"}, {30'd0, mode}, {30'd0, old_mode});
    tick();
    chk({name, "_mode"}, {30'd0, mode}, {30'd0, new_mode});
    btn = 1'b0;
    repeat (6) tick();
  endtask

  task automatic wait_change(output int n);
    logic [7:0] p;
    p = led;
    n = 0;
    do begin
      tick();
      n++;
    end while (led == p && n < 100);
    total++;
    if (led == p) begin
      bad++;
      $display("FAIL step_timeout: led stuck at %0h for %0d cycles", led, n);
    end
  endtask

  initial begin
    int n;
    logic [7:0] prev;
    logic [7:0] l0;
    logic [2:0] s0;

    vt[0] = '{1'b1, 1'b1, 8'h02, 3'd0, 2'd0};
    vt[1] = '{1'b1, 1'b1, 8'h04, 3'd0, 2'd0};
    vt[2] = '{1'b1, 1'b1, 8'h08, 3'd0, 2'd0};
    vt[3] = '{1'b0, 1'b1, 8'h04, 3'd0, 2'd0};
    vt[4] = '{1'b0, 1'b1, 8'h02, 3'd0, 2'd0};
    vt[5] = '{1'b0, 1'b1, 8'h01, 3'd0, 2'd0};
    vt[6] = '{1'b0, 1'b1, 8'h80, 3'd0, 2'd0};
    vt[7]  = '{1'b1, 1'b0, 8'h00, 3'd1, 2'd1};
    vt[8]  = '{1'b1, 1'b0, 8'h00, 3'd2, 2'd1};
    vt[9]  = '{1'b1, 1'b0, 8'h00, 3'd3, 2'd1};
    vt[10] = '{1'b1, 1'b0, 8'h00, 3'd4, 2'd1};
    vt[11] = '{1'b1, 1'b0, 8'h00, 3'd5, 2'd1};
    vt[12] = '{1'b1, 1'b0, 8'h00, 3'd6, 2'd1};
    vt[13] = '{1'b1, 1'b0, 8'h00, 3'd7, 2'd1};
    vt[14] = '{1'b1, 1'b0, 8'h00, 3'd7, 2'd1};
    vt[15] = '{1'b1, 1'b0, 8'h00, 3'd7, 2'd1};
    vt[16] = '{1'b0, 1'b0, 8'h00, 3'd6, 2'd1};
    vt[17] = '{1'b0, 1'b0, 8'h00, 3'd5, 2'd1};
    vt[18] = '{1'b0, 1'b0, 8'h00, 3'd4, 2'd1};
    vt[19] = '{1'b0, 1'b0, 8'h00, 3'd3, 2'd1};
    vt[20] = '{1'b0, 1'b0, 8'h00, 3'd2, 2'd1};
    vt[21] = '{1'b0, 1'b0, 8'h00, 3'd1, 2'd1};
    vt[22] = '{1'b0, 1'b0, 8'h00, 3'd0, 2'd1};
    vt[23] = '{1'b0, 1'b0, 8'h00, 3'd0, 2'd1};
    vt[24] = '{1'b0, 1'b0, 8'h00, 3'd0, 2'd1};

    rst = 1'b1; rot_event = 1'b0; rot_dir = 1'b0; btn = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_led", {24'd0, led}, 32'h01);
    chk("reset_mode", {30'd0, mode}, 32'd0);
    chk("reset_speed", {29'd0, speed}, 32'd0);

    // Manual stepping, wrap past 01 going right.
    run_vecs(0, 6);

    // Bouncing button never qualifies.
    for (int i = 0; i < 20; i++) begin
      btn = ((i / 2) % 2 == 0);
      tick();
      chk("bounce_mode", {30'd0, mode}, 32'd0);
    end
    btn = 1'b0;
    repeat (6) tick();
    press_btn(2'd0, 2'd1, "press_auto");

    // AUTO speed up to saturation, auto direction is right from the last manual event.
    run_vecs(7, 15);
    wait_change(n);
    prev = led;
    wait_change(n);
    chk("fast_period", n, 32'd4);
    chk("fast_dir", {24'd0, led}, {24'd0, prev[0], prev[7:1]});

    run_vecs(16, 24);
    wait_change(n);
    prev = led;
    wait_change(n);
    chk("slow_period", n, 32'd32);
    chk("slow_dir", {24'd0, led}, {24'd0, prev[0], prev[7:1]});

    // FREEZE holds everything.
    press_btn(2'd1, 2'd2, "press_freeze");
    l0 = led;
    s0 = speed;
    for (int i = 0; i < 5; i++) begin
      rot_event = 1'b1;
      rot_dir   = i[0];
      tick();
      rot_event = 1'b0;
      tick();
    end
    repeat (100) tick();
    chk("freeze_led", {24'd0, led}, {24'd0, l0});
    chk("freeze_speed", {29'd0, speed}, {29'd0, s0});
    press_btn(2'd2, 2'd0, "press_manual");

    // Press pulse and rotary event in the same cycle.
    l0 = led;
    btn = 1'b1;
    repeat (5) tick();
    rot_event = 1'b1;
    rot_dir   = 1'b1;
    tick();
    rot_event = 1'b0;
    chk("collide_mode", {30'd0, mode}, 32'd1);
    chk("collide_led", {24'd0, led}, {24'd0, l0});
    chk("collide_speed", {29'd0, speed}, 32'd0);
    btn = 1'b0;
    repeat (6) tick();

    // Back to MANUAL, walk to 40 going left, then run AUTO at speed 0.
    press_btn(2'd1, 2'd2, "press_freeze2");
    press_btn(2'd2, 2'd0, "press_manual2");
    for (int i = 0; i < 9; i++) begin
      if (i == 0 || led != 8'h40) begin
        rot_event = 1'b1;
        rot_dir   = 1'b1;
        tick();
        rot_event = 1'b0;
      end
    end
    chk("walk_led", {24'd0, led}, 32'h40);
    press_btn(2'd0, 2'd1, "press_auto2");
    wait_change(n);
    chk("edge_first_wait", n, 32'd26);
    chk("edge_first_led", {24'd0, led}, 32'h80);
    wait_change(n);
    chk("edge_second_wait", n, 32'd32);
`ifdef ROT_CTRL_PINGPONG_EN
    chk("edge_second_led", {24'd0, led}, 32'h40);
`else
    chk("edge_second_led", {24'd0, led}, 32'h01);
`endif

    // Reset mid-run.
    for (int i = 0; i < 2; i++) begin
      rot_event = 1'b1;
      rot_dir   = 1'b1;
      tick();
      rot_event = 1'b0;
    end
    chk("pre_rst_speed", {29'd0, speed}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_led", {24'd0, led}, 32'h01);
    chk("midrst_mode", {30'd0, mode}, 32'd0);
    chk("midrst_speed", {29'd0, speed}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
